// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB master bridge and its benches.
// Holds the bridge state encoding, the slave region codes decoded from
// address bits [31:28], and the GPIO register offsets inside slave 0.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERR    = 2'd3
  } apb_state_e;

  // Region codes found in address bits [31:28]
  localparam logic [3:0] ADDR_SLAVE_0 = 4'h0;
  localparam logic [3:0] ADDR_SLAVE_1 = 4'h1;

  // GPIO register offsets within slave 0
  localparam logic [3:0] DATA_RO = 4'h0;
  localparam logic [3:0] DATA    = 4'h4;
  localparam logic [3:0] DIRM    = 4'h8;
  localparam logic [3:0] OEN     = 4'hC;

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps the top address nibble to a one-hot slave select.
// Any region other than slave 0 or slave 1 is flagged as unmapped and
// produces an all-zero select, so it can never reach the bus.
module apb_addr_decoder
  import apb_pkg::*;
(
  input  logic [3:0] region_i,
  output logic [1:0] sel_o,
  output logic       unmapped_o
);

  // Region nibble to one-hot select / unmapped flag.
  always_comb begin
    sel_o      = 2'b00;
    unmapped_o = 1'b1;
    case (region_i)
      ADDR_SLAVE_0: begin
        sel_o      = 2'b01;
        unmapped_o = 1'b0;
      end
      ADDR_SLAVE_1: begin
        sel_o      = 2'b10;
        unmapped_o = 1'b0;
      end
      default: begin
        sel_o      = 2'b00;
        unmapped_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB initiator fed by a valid/ready
// command port. Runs SETUP/ACCESS, returns read data or an error on a
// one-cycle response strobe in the first IDLE cycle after completion.
// Optional build macro: APB_TIMEOUT_EN -- when defined, an ACCESS phase that
// sees no PREADY for TIMEOUT_CYCLES cycles is abandoned with an error response.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32
) (
  input  logic              iPCLK,
  input  logic              iPRESET,
  input  logic              iCMD_VALID,
  output logic              oCMD_READY,
  input  logic              iCMD_WRITE,
  input  logic [ADDR_W-1:0] iCMD_ADDR,
  input  logic [DATA_W-1:0] iCMD_WDATA,
  output logic              oRSP_VALID,
  output logic [DATA_W-1:0] oRSP_RDATA,
  output logic              oRSP_ERR,
  output logic [ADDR_W-1:0] oPADDR,
  output logic [1:0]        oPSEL,
  output logic              oPENABLE,
  output logic              oPWRITE,
  output logic [DATA_W-1:0] oPWDATA,
  input  logic              iPREADY0,
  input  logic              iPREADY1,
  input  logic [DATA_W-1:0] iPRDATA0,
  input  logic [DATA_W-1:0] iPRDATA1
);

  apb_state_e        state_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [1:0]        psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;

  // Select the decoder would grant to the command currently offered
  logic [1:0]        sel_d;
  logic              unmapped_d;

  // Ready/data of whichever slave owns the current transfer
  logic              sel_pready;
  logic [DATA_W-1:0] sel_prdata;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q;
`endif

  apb_addr_decoder u_addr_decoder (
    .region_i   (iCMD_ADDR[ADDR_W-1 -: 4]),
    .sel_o      (sel_d),
    .unmapped_o (unmapped_d)
  );

  // Route only the selected slave's PREADY/PRDATA; the other slave is ignored.
  always_comb begin
    sel_pready = 1'b0;
    sel_prdata = {DATA_W{1'b0}};
    if (psel_q[0]) begin
      sel_pready = iPREADY0;
      sel_prdata = iPRDATA0;
    end else if (psel_q[1]) begin
      sel_pready = iPREADY1;
      sel_prdata = iPRDATA1;
    end else begin
      sel_pready = 1'b0;
      sel_prdata = {DATA_W{1'b0}};
    end
  end

  // Bridge FSM; every output is a register so the bus never sees glitches.
  always_ff @(posedge iPCLK or posedge iPRESET) begin
    if (iPRESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
      paddr_q     <= {ADDR_W{1'b0}};
      psel_q      <= 2'b00;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= {DATA_W{1'b0}};
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= {TMO_W{1'b0}};
`endif
    end else begin
      // Response fields are single-cycle strobes unless set below
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iCMD_VALID && unmapped_d) begin
            // Unmapped commands bypass the bus entirely
            state_q     <= ERR;
            cmd_ready_q <= 1'b0;
          end else if (iCMD_VALID) begin
            state_q     <= SETUP;
            cmd_ready_q <= 1'b0;
            paddr_q     <= iCMD_ADDR;
            pwrite_q    <= iCMD_WRITE;
            pwdata_q    <= iCMD_WDATA;
            psel_q      <= sel_d;
            penable_q   <= 1'b0;
          end else begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
          tmo_cnt_q <= {TMO_W{1'b0}};
`endif
        end
        ACCESS: begin
          if (sel_pready) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? {DATA_W{1'b0}} : sel_prdata;
            paddr_q     <= {ADDR_W{1'b0}};
            psel_q      <= 2'b00;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= {DATA_W{1'b0}};
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            // Slave never answered: drop the bus and report an error
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            paddr_q     <= {ADDR_W{1'b0}};
            psel_q      <= 2'b00;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= {DATA_W{1'b0}};
          end else begin
            tmo_cnt_q   <= tmo_cnt_q + TMO_W'(1);
          end
`else
          else begin
            state_q     <= ACCESS;
          end
`endif
        end
        ERR: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          paddr_q     <= {ADDR_W{1'b0}};
          psel_q      <= 2'b00;
          penable_q   <= 1'b0;
          pwrite_q    <= 1'b0;
          pwdata_q    <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

  assign oCMD_READY = cmd_ready_q;
  assign oRSP_VALID = rsp_valid_q;
  assign oRSP_RDATA = rsp_rdata_q;
  assign oRSP_ERR   = rsp_err_q;
  assign oPADDR     = paddr_q;
  assign oPSEL      = psel_q;
  assign oPENABLE   = penable_q;
  assign oPWRITE    = pwrite_q;
  assign oPWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: table-driven vectors, hand-written corner sequences
// and randomized traffic checked against a memory-level reference model.
// A reactive slave model with programmable wait states sits on both slots.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int TMO       = 16;
  localparam int RSP_LIMIT = 60;

  logic        iPCLK, iPRESET;
  logic        iCMD_VALID, iCMD_WRITE;
  logic [31:0] iCMD_ADDR, iCMD_WDATA;
  logic        oCMD_READY, oRSP_VALID, oRSP_ERR;
  logic [31:0] oRSP_RDATA, oPADDR, oPWDATA;
  logic [1:0]  oPSEL;
  logic        oPENABLE, oPWRITE;
  logic        iPREADY0, iPREADY1;
  logic [31:0] iPRDATA0, iPRDATA1;

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32), .DATA_W(32)) dut (
    .iPCLK(iPCLK), .iPRESET(iPRESET),
    .iCMD_VALID(iCMD_VALID), .oCMD_READY(oCMD_READY), .iCMD_WRITE(iCMD_WRITE),
    .iCMD_ADDR(iCMD_ADDR), .iCMD_WDATA(iCMD_WDATA),
    .oRSP_VALID(oRSP_VALID), .oRSP_RDATA(oRSP_RDATA), .oRSP_ERR(oRSP_ERR),
    .oPADDR(oPADDR), .oPSEL(oPSEL), .oPENABLE(oPENABLE), .oPWRITE(oPWRITE),
    .oPWDATA(oPWDATA),
    .iPREADY0(iPREADY0), .iPREADY1(iPREADY1),
    .iPRDATA0(iPRDATA0), .iPRDATA1(iPRDATA1)
  );

  initial iPCLK = 1'b0;
  always #5 iPCLK = ~iPCLK;

  // ---------------- slave model ----------------
  function automatic logic [31:0] init0(int k);
    return 32'hA5A5_0003 + 32'(k);
  endfunction
  function automatic logic [31:0] init1(int k);
    return 32'h5A5A_0000 ^ 32'(k);
  endfunction

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic        mem_load;
  int          wait_cfg;
  logic        noise0, noise1;
  logic [7:0]  acc_cnt;

  always @(posedge iPCLK) begin
    if (oPENABLE) acc_cnt <= acc_cnt + 8'd1;
    else          acc_cnt <= 8'd0;
    if (mem_load) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= init0(i);
        mem1[i] <= init1(i);
      end
    end else if (oPENABLE && oPWRITE) begin
      if (oPSEL[0] && iPREADY0) mem0[oPADDR[9:2]] <= oPWDATA;
      if (oPSEL[1] && iPREADY1) mem1[oPADDR[9:2]] <= oPWDATA;
    end
  end

  assign iPREADY0 = (oPSEL[0] && oPENABLE) ? (int'(acc_cnt) >= wait_cfg) : noise0;
  assign iPREADY1 = (oPSEL[1] && oPENABLE) ? (int'(acc_cnt) >= wait_cfg) : noise1;
  assign iPRDATA0 = mem0[oPADDR[9:2]];
  assign iPRDATA1 = mem1[oPADDR[9:2]];

  // ---------------- reference model ----------------
  logic [31:0] ref0 [int];
  logic [31:0] ref1 [int];

  function automatic logic [31:0] ref_read(logic [31:0] addr);
    int k;
    k = int'(addr[9:2]);
    if (addr[31:28] == 4'h0) return ref0.exists(k) ? ref0[k] : init0(k);
    else if (addr[31:28] == 4'h1) return ref1.exists(k) ? ref1[k] : init1(k);
    else return 32'h0;
  endfunction

  task automatic ref_write(logic [31:0] addr, logic [31:0] data);
    if (addr[31:28] == 4'h0) ref0[int'(addr[9:2])] = data;
    else if (addr[31:28] == 4'h1) ref1[int'(addr[9:2])] = data;
  endtask

  // ---------------- helpers ----------------
  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iPCLK);
    #1;
  endtask

  task automatic wait_ready(string tag);
    int n;
    n = 0;
    while (!oCMD_READY && n < 40) begin
      step();
      n++;
    end
    if (!oCMD_READY) check({tag, "_ready_wait"}, 128'(0), 128'(1));
  endtask

  // Issue one command and follow it cycle by cycle until its response.
  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int wt, input bit exp_err, input logic [31:0] exp_rdata,
                        input int exp_lat, input string tag);
    logic [1:0]  exp_sel;
    logic [68:0] exp_bus;
    int          n;
    bit          done;
    case (addr[31:28])
      4'h0:    exp_sel = 2'b01;
      4'h1:    exp_sel = 2'b10;
      default: exp_sel = 2'b00;
    endcase
    wait_ready(tag);
    wait_cfg   = wt;
    iCMD_VALID = 1'b1;
    iCMD_WRITE = wr;
    iCMD_ADDR  = addr;
    iCMD_WDATA = wdata;
    step();
    iCMD_VALID = 1'b0;
    iCMD_WRITE = 1'($urandom);
    iCMD_ADDR  = $urandom;
    iCMD_WDATA = $urandom;
    n = 1;
    done = 1'b0;
    while (!done) begin
      if (exp_sel == 2'b00 || n >= exp_lat) exp_bus = {(n >= exp_lat), 68'h0};
      else exp_bus = {1'b0, exp_sel, (n >= 2), wr, addr, wdata};
      check({tag, "_bus"}, 128'({oCMD_READY, oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA}),
            128'(exp_bus));
      if (oRSP_VALID) done = 1'b1;
      else if (n >= RSP_LIMIT) done = 1'b1;
      else begin
        step();
        n++;
      end
    end
    check({tag, "_latency"}, 128'(n), 128'(exp_lat));
    check({tag, "_rsp"}, 128'({oRSP_VALID, oRSP_ERR, oRSP_RDATA}), 128'({1'b1, exp_err, exp_rdata}));
    step();
    check({tag, "_rsp_clear"}, 128'({oRSP_VALID, oRSP_ERR, oRSP_RDATA}), 128'(0));
    if (wr && !exp_err) ref_write(addr, wdata);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wt;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    iPRESET    = 1'b1;
    iCMD_VALID = 1'b0;
    iCMD_WRITE = 1'b0;
    iCMD_ADDR  = 32'h0;
    iCMD_WDATA = 32'h0;
    mem_load   = 1'b1;
    wait_cfg   = 0;
    noise0     = 1'b1;
    noise1     = 1'b1;
    step();
    step();
    check("reset_outputs",
          128'({oCMD_READY, oRSP_VALID, oRSP_RDATA, oRSP_ERR, oPADDR, oPSEL, oPENABLE, oPWRITE, oPWDATA}),
          128'({1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0}));
    mem_load = 1'b0;
    iPRESET  = 1'b0;
    step();

    // ---- table-driven vectors ----
    vecs.push_back('{1'b1, {28'h0, DIRM},   32'h0000_00F0, 0, 1'b0, 32'h0,          3});
    vecs.push_back('{1'b0, {28'h0, DIRM},   32'h0,         0, 1'b0, 32'h0000_00F0,  3});
    vecs.push_back('{1'b0, {28'h0, DATA_RO},32'h0,         0, 1'b0, 32'hA5A5_0003,  3});
    vecs.push_back('{1'b0, 32'h1000_0010,   32'h0,         3, 1'b0, 32'h5A5A_0004,  6});
    vecs.push_back('{1'b1, 32'h2000_0000,   32'h1111_1111, 0, 1'b1, 32'h0,          2});
    vecs.push_back('{1'b0, 32'hF000_0004,   32'h0,         0, 1'b1, 32'h0,          2});
    vecs.push_back('{1'b1, 32'h1000_0010,   32'hDEAD_BEEF, 1, 1'b0, 32'h0,          4});
    vecs.push_back('{1'b0, 32'h1000_0010,   32'h0,         2, 1'b0, 32'hDEAD_BEEF,  5});
    vecs.push_back('{1'b0, {28'h0, OEN},    32'h0,         0, 1'b0, 32'hA5A5_0006,  3});
    vecs.push_back('{1'b0, 32'h1FFF_FC04,   32'h0,         0, 1'b0, 32'h5A5A_0001,  3});
    for (int i = 0; i < vecs.size(); i++) begin
      do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wt,
             vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // ---- back-to-back writes with iCMD_VALID held high ----
    begin
      int  idx, nrsp, last, gap_bad, rdy_bad, err_seen;
      bit  prev_ready;
      wait_ready("b2b");
      wait_cfg   = 0;
      idx        = 0;
      nrsp       = 0;
      last       = 0;
      gap_bad    = 0;
      rdy_bad    = 0;
      err_seen   = 0;
      iCMD_VALID = 1'b1;
      iCMD_WRITE = 1'b1;
      iCMD_ADDR  = 32'h0000_0040;
      iCMD_WDATA = 32'hB0B0_0000;
      prev_ready = 1'b1;
      for (int c = 1; c <= 12; c++) begin
        step();
        if (prev_ready && iCMD_VALID) begin
          idx++;
          if (idx < 4) begin
            iCMD_ADDR  = 32'h0000_0040 + 32'(4 * idx);
            iCMD_WDATA = 32'hB0B0_0000 + 32'(idx);
          end else begin
            iCMD_VALID = 1'b0;
          end
        end
        if (oRSP_VALID) begin
          if (c - last != 3) gap_bad++;
          if (oRSP_ERR) err_seen++;
          nrsp++;
          last = c;
        end
        if (oCMD_READY != oRSP_VALID) rdy_bad++;
        prev_ready = oCMD_READY;
      end
      check("b2b_responses", 128'(nrsp), 128'(4));
      check("b2b_gap", 128'(gap_bad), 128'(0));
      check("b2b_ready_only_idle", 128'(rdy_bad), 128'(0));
      check("b2b_err", 128'(err_seen), 128'(0));
      for (int k = 0; k < 4; k++) ref_write(32'h0000_0040 + 32'(4 * k), 32'hB0B0_0000 + 32'(k));
      step();
      for (int k = 0; k < 4; k++)
        do_cmd(1'b0, 32'h0000_0040 + 32'(4 * k), 32'h0, 0, 1'b0,
               32'hB0B0_0000 + 32'(k), 3, $sformatf("b2b_rd%0d", k));
    end

    // ---- stuck PREADY ----
`ifdef APB_TIMEOUT_EN
    do_cmd(1'b0, 32'h0000_0004, 32'h0, 100, 1'b1, 32'h0, 2 + TMO, "timeout");
`else
    do_cmd(1'b0, 32'h0000_0004, 32'h0, 20, 1'b0, ref_read(32'h0000_0004), 23, "long_wait");
`endif

    // ---- reset mid-ACCESS ----
    begin
      int rsp_seen, bus_seen;
      wait_ready("rst");
      wait_cfg   = 30;
      iCMD_VALID = 1'b1;
      iCMD_WRITE = 1'b0;
      iCMD_ADDR  = 32'h0000_0004;
      step();
      iCMD_VALID = 1'b0;
      step();
      step();
      check("rst_pre_access", 128'({oPSEL, oPENABLE}), 128'({2'b01, 1'b1}));
      #2;
      iPRESET = 1'b1;
      #1;
      check("rst_async_clear",
            128'({oCMD_READY, oRSP_VALID, oPSEL, oPENABLE, oPADDR}),
            128'({1'b1, 1'b0, 2'b00, 1'b0, 32'h0}));
      step();
      iPRESET  = 1'b0;
      rsp_seen = 0;
      bus_seen = 0;
      for (int c = 0; c < 8; c++) begin
        step();
        if (oRSP_VALID) rsp_seen++;
        if (oPSEL != 2'b00) bus_seen++;
      end
      check("rst_no_response", 128'(rsp_seen), 128'(0));
      check("rst_bus_idle", 128'(bus_seen), 128'(0));
    end

    // ---- randomized traffic against the reference model ----
    for (int t = 0; t < 40; t++) begin
      int          r, wt, gap;
      logic [3:0]  region;
      logic [31:0] addr, wdata, exp_rd;
      bit          wr, err;
      r = $urandom_range(0, 7);
      if (r < 3)       region = 4'h0;
      else if (r < 6)  region = 4'h1;
      else if (r == 6) region = 4'h2;
      else             region = 4'($urandom_range(2, 15));
      addr   = {region, 18'($urandom), 8'($urandom), 2'b00};
      wdata  = $urandom;
      wr     = 1'($urandom);
      wt     = $urandom_range(0, 5);
      noise0 = 1'($urandom);
      noise1 = 1'($urandom);
      err    = (region > 4'h1);
      exp_rd = (!wr && !err) ? ref_read(addr) : 32'h0;
      gap    = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      do_cmd(wr, addr, wdata, wt, err, exp_rd, err ? 2 : 3 + wt, $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB initiator that drives the APB bus toward the AMBA peripheral slaves.
- Accepts simple valid/ready read/write commands from a local controller (CPU-less test logic, key/LED sequencer).
- Runs the APB SETUP/ACCESS phases and returns read data or error on a one-cycle response strobe.
- Decodes iCMD_ADDR[31:28] to select slave 0 (GPIO) or slave 1; unmapped addresses never reach the bus.

Parameters:
- TIMEOUT_CYCLES, 16, max ACCESS-phase cycles waiting for PREADY (used only with the optional feature).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.

Ports:
- iPCLK  in  1  APB clock
- iPRESET  in  1  asynchronous reset, active-high
- iCMD_VALID  in  1  command request
- oCMD_READY  out  1  bridge can accept a command
- iCMD_WRITE  in  1  1=write, 0=read
- iCMD_ADDR  in  ADDR_W  full address
- iCMD_WDATA  in  DATA_W  write data
- oRSP_VALID  out  1  one-cycle response strobe
- oRSP_RDATA  out  DATA_W  read data; 0 for writes and errors
- oRSP_ERR  out  1  unmapped address or timeout
- oPADDR  out  ADDR_W  APB address
- oPSEL  out  2  one-hot select; bit0=slave 0, bit1=slave 1
- oPENABLE  out  1  APB enable
- oPWRITE  out  1  APB direction
- oPWDATA  out  DATA_W  APB write data
- iPREADY0 / iPREADY1  in  1  slave ready
- iPRDATA0 / iPRDATA1  in  DATA_W  slave read data

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0 except oCMD_READY=1.
- Reset mid-transfer drops PSEL/PENABLE in the same instant and loses any pending response.
- States:
  - IDLE: oCMD_READY=1. On iCMD_VALID, latch write/addr/wdata.
    - addr[31:28]=4'h0 → SETUP with PSEL=01.
    - addr[31:28]=4'h1 → SETUP with PSEL=10.
    - any other value → ERR.
  - SETUP: PSEL set, PENABLE=0, PADDR/PWRITE/PWDATA stable. Always → ACCESS next cycle.
  - ACCESS: PSEL and PENABLE=1; all bus signals held stable.
    - When the selected iPREADYx=1 at a clock edge: capture the matching iPRDATAx (reads only) → IDLE.
    - Otherwise stay in ACCESS (wait states).
  - ERR: no PSEL. → IDLE next cycle with oRSP_ERR=1.
- Response timing: oRSP_VALID pulses for exactly one cycle, in the first IDLE cycle after completion.
  - oRSP_RDATA/oRSP_ERR are valid only in that cycle and return to 0 afterwards.
- oCMD_READY is registered from state, so it is high only in IDLE. A new command can be accepted in the same cycle as the previous response.
- Latency with zero wait states, accept at edge 0:
  - SETUP in cycle 1, ACCESS in cycle 2, response in cycle 3.
  - Peak throughput: one transfer per 3 cycles.
- oPADDR/oPWDATA/oPWRITE return to 0 in IDLE. iPREADY of the non-selected slave is ignored.
- iCMD_VALID while not ready is ignored; the command interface does not buffer.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: an ACCESS-cycle counter is reset on entering ACCESS.
  - If PREADY is still low after TIMEOUT_CYCLES ACCESS cycles, the transfer is abandoned: PSEL/PENABLE drop, state goes to IDLE, and the response has oRSP_ERR=1 and RDATA=0.
- Not defined: ACCESS waits indefinitely and no counter logic exists.

Decomposition:
- Package apb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, ERR};
  - slave base constants ADDR_SLAVE_0=4'h0 and ADDR_SLAVE_1=4'h1;
  - GPIO offsets DATA_RO=4'h0, DATA=4'h4, DIRM=4'h8, OEN=4'hC, shared with benches.
- One sub-module, apb_addr_decoder: a combinational map from addr[31:28] to one-hot select plus an unmapped flag.

Test Plan:
- Write 0x0000_0008 ← 0x0000_00F0 with iPREADY0 tied 1:
  - PSEL=01, PENABLE=0 in cycle 1; PENABLE=1 in cycle 2; response in cycle 3 with ERR=0.
  - A following read of 0x0000_0008 returns RDATA=0x0000_00F0.
- Read 0x0000_0000 with iPRDATA0=0xA5A5_0003:
  - oRSP_RDATA=0xA5A5_0003 on the single-cycle oRSP_VALID.
- Slave 1 read with iPREADY1 low for 3 cycles:
  - PSEL=10 and PENABLE held for 4 ACCESS cycles with stable PADDR; response is 1 cycle after PREADY.
- Address 0x2000_0000:
  - no PSEL ever asserted; oRSP_ERR=1 two cycles after acceptance.
- Back-to-back commands with iCMD_VALID held high:
  - a transfer completes every 3 cycles; oCMD_READY never high outside IDLE.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and iPREADY0 stuck low:
  - ERR response after 16 ACCESS cycles.
  - iPRESET asserted mid-ACCESS clears PSEL/PENABLE immediately and produces no response.
